// File: rtl/sm_1153_pick_drop_sched_if.sv
// Job offer channel for the pick/drop scheduler: one (pick, drop) node pair
// per accepted valid/ready handshake.
interface sm_1153_pick_drop_sched_if #(
    parameter int NODE_W = 32
);
    logic              job_valid;
    logic              job_ready;
    logic [NODE_W-1:0] job_pick;
    logic [NODE_W-1:0] job_drop;

    // Job source (host / mission controller)
    modport master (
        output job_valid,
        output job_pick,
        output job_drop,
        input  job_ready
    );

    // Scheduler side
    modport slave (
        input  job_valid,
        input  job_pick,
        input  job_drop,
        output job_ready
    );
endinterface

// File: rtl/sm_1153_pick_drop_sched.sv
// Pick/drop job sequencer for the soil-monitoring bot electromagnet.
// Queues (pick, drop) node pairs, steers the planner to each node in turn,
// and times the magnet grab/release settle windows.
module sm_1153_pick_drop_sched #(
    parameter int NODE_W     = 32,
    parameter int QDEPTH     = 4,
    parameter int SETTLE_CYC = 2500000
) (
    input  logic                       clk_50,
    input  logic                       rst_n,
    sm_1153_pick_drop_sched_if.slave   job,
    input  logic [NODE_W-1:0]          node,
    input  logic                       node_detected,
    output logic [NODE_W-1:0]          target_node,
    output logic                       target_valid,
    output logic                       control_mag,
    output logic                       pick_message,
    output logic                       drop_message,
    output logic                       busy,
    output logic [7:0]                 jobs_done
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(QDEPTH);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        GO_PICK,
        GRAB,
        GO_DROP,
        RELEASE
    } state_t;

    logic [NODE_W-1:0] pick_mem [QDEPTH];
    logic [NODE_W-1:0] drop_mem [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    state_t            state;
    state_t            state_next;
    logic [NODE_W-1:0] cur_pick;
    logic [NODE_W-1:0] cur_drop;
    logic [NODE_W-1:0] target_next;
    logic [SET_W-1:0]  settle_cnt;
    logic              settle_done;
    logic              node_detected_q;
    logic              arrive;

    // Full is judged on the registered count only, so a same-cycle pop
    // never lets a push into a full queue.
    assign job.job_ready = (count != FULL_COUNT);
    assign push          = job.job_valid && job.job_ready;
    assign fifo_empty    = (count == '0);
    assign pop           = (state == IDLE) && !fifo_empty;

    // Only a fresh rising edge of node_detected at the current target counts;
    // sitting on a node with the sensor held high never re-triggers.
    assign arrive      = node_detected && !node_detected_q && (node == target_node);
    assign settle_done = (settle_cnt == SETTLE_LAST);

    // Job storage; data needs no reset because count gates every read
    always_ff @(posedge clk_50) begin
        if (push) begin
            pick_mem[wr_ptr] <= job.job_pick;
            drop_mem[wr_ptr] <= job.job_drop;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Job sequencing: travel, grab, travel, release
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = GO_PICK;
            GO_PICK: if (arrive)      state_next = GRAB;
            GRAB:    if (settle_done) state_next = GO_DROP;
            GO_DROP: if (arrive)      state_next = RELEASE;
            RELEASE: if (settle_done) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Planner target for the upcoming state; the head of the queue is used
    // directly on the pop cycle since cur_pick is only loaded at that edge
    always_comb begin
        target_next = '0;
        case (state_next)
            GO_PICK: target_next = (state == IDLE) ? pick_mem[rd_ptr] : cur_pick;
            GO_DROP: target_next = cur_drop;
            default: target_next = '0;
        endcase
    end

    // State, current job, settle timer and registered outputs
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cur_pick        <= '0;
            cur_drop        <= '0;
            settle_cnt      <= '0;
            node_detected_q <= 1'b0;
            target_node     <= '0;
            target_valid    <= 1'b0;
            control_mag     <= 1'b0;
            pick_message    <= 1'b0;
            drop_message    <= 1'b0;
            busy            <= 1'b0;
            jobs_done       <= '0;
        end else begin
            state           <= state_next;
            node_detected_q <= node_detected;

            if (pop) begin
                cur_pick <= pick_mem[rd_ptr];
                cur_drop <= drop_mem[rd_ptr];
            end

            if (state_next != state) begin
                settle_cnt <= '0;
            end else if ((state == GRAB) || (state == RELEASE)) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end

            target_node  <= target_next;
            target_valid <= (state_next == GO_PICK) || (state_next == GO_DROP);
            control_mag  <= (state_next == GRAB) || (state_next == GO_DROP);
            pick_message <= (state == GRAB) && settle_done;
            drop_message <= (state == RELEASE) && settle_done;
            busy         <= (state_next != IDLE);

            if ((state == RELEASE) && settle_done) begin
                jobs_done <= jobs_done + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sm_1153_pick_drop_sched.sv
// Scoreboard bench for the pick/drop scheduler (SETTLE_CYC=4, QDEPTH=4).
module tb_sm_1153_pick_drop_sched;

    localparam int NODE_W = 32;
    localparam int QDEPTH = 4;
    localparam int SETTLE = 4;

    localparam logic [1:0] EV_TGT  = 2'd0;
    localparam logic [1:0] EV_PICK = 2'd1;
    localparam logic [1:0] EV_DROP = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;

    logic              clk_50 = 1'b0;
    logic              rst_n  = 1'b0;
    logic [NODE_W-1:0] node   = '0;
    logic              node_detected = 1'b0;
    logic [NODE_W-1:0] target_node;
    logic              target_valid;
    logic              control_mag;
    logic              pick_message;
    logic              drop_message;
    logic              busy;
    logic [7:0]        jobs_done;

    int         total = 0;
    int         bad   = 0;
    ev_t        exp_q[$];
    logic [7:0] exp_done = 8'd0;
    logic       tv_prev  = 1'b0;

    sm_1153_pick_drop_sched_if #(.NODE_W(NODE_W)) job_if ();

    sm_1153_pick_drop_sched #(
        .NODE_W     (NODE_W),
        .QDEPTH     (QDEPTH),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk_50        (clk_50),
        .rst_n         (rst_n),
        .job           (job_if),
        .node          (node),
        .node_detected (node_detected),
        .target_node   (target_node),
        .target_valid  (target_valid),
        .control_mag   (control_mag),
        .pick_message  (pick_message),
        .drop_message  (drop_message),
        .busy          (busy),
        .jobs_done     (jobs_done)
    );

    always #5 clk_50 = ~clk_50;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [1:0] kind, input logic [31:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: actual=event kind %0d val %0h required=no event", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            checkOutput(name, {30'd0, kind, val}, {30'd0, e.kind, e.val});
        end
    endtask

    // Each accepted job must produce: target(pick), pick pulse with magnet on,
    // target(drop), drop pulse with the incremented counter.
    task automatic expect_job(input logic [31:0] p, input logic [31:0] d);
        exp_q.push_back('{kind: EV_TGT,  val: p});
        exp_q.push_back('{kind: EV_PICK, val: 32'd1});
        exp_q.push_back('{kind: EV_TGT,  val: d});
        exp_done = exp_done + 8'd1;
        exp_q.push_back('{kind: EV_DROP, val: {24'd0, exp_done}});
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] d);
        int n = 0;
        job_if.job_pick  = p;
        job_if.job_drop  = d;
        job_if.job_valid = 1'b1;
        while (!job_if.job_ready && n < 200) begin
            tick();
            n++;
        end
        if (!job_if.job_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL push timeout: actual=job_ready 0 required=1");
            job_if.job_valid = 1'b0;
        end else begin
            tick();
            job_if.job_valid = 1'b0;
            expect_job(p, d);
        end
    endtask

    // which: 0 target_valid, 1 pick_message, 2 drop_message
    task automatic wait_sig(input int which, input string name, output int n);
        logic hit = 1'b0;
        n = 0;
        while (!hit && n < 40) begin
            tick();
            n++;
            case (which)
                0:       hit = target_valid;
                1:       hit = pick_message;
                2:       hit = drop_message;
                default: hit = 1'b1;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: actual=no event required=event within 40 cycles", name);
        end
    endtask

    task automatic arrive(input logic [31:0] n);
        node          = n;
        node_detected = 1'b1;
        tick();
        node_detected = 1'b0;
    endtask

    task automatic finish_job(input logic [31:0] p, input logic [31:0] d);
        int n;
        wait_sig(0, "job target", n);
        arrive(p);
        wait_sig(1, "job pick", n);
        arrive(d);
        wait_sig(2, "job drop", n);
    endtask

    task automatic run_job(input logic [31:0] p, input logic [31:0] d);
        applyStimulus(p, d);
        finish_job(p, d);
    endtask

    // Asserts reset mid-cycle (no clock edge involved) and checks the
    // asynchronous clear before releasing it.
    task automatic mid_cycle_reset(input string tag);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_done = 8'd0;
        job_if.job_valid = 1'b0;
        node_detected = 1'b0;
        #1;
        checkOutput({tag, " async mag"}, control_mag, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " target_valid"}, target_valid, 0);
        checkOutput({tag, " jobs_done"}, jobs_done, 0);
        checkOutput({tag, " job_ready"}, job_if.job_ready, 1);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checkOutput({tag, " fifo empty busy"}, busy, 0);
        checkOutput({tag, " fifo empty tv"}, target_valid, 0);
    endtask

    // Monitor: every output event is matched against the next expectation
    always @(negedge clk_50) begin
        if (!rst_n) begin
            tv_prev = 1'b0;
        end else begin
            if (pick_message) begin
                checkOutput("pulse overlap", drop_message, 0);
                sb_check("sb pick", EV_PICK, {31'd0, control_mag});
            end
            if (drop_message) begin
                sb_check("sb drop", EV_DROP, {24'd0, jobs_done});
            end
            if (target_valid && !tv_prev) begin
                sb_check("sb target", EV_TGT, target_node);
            end
            tv_prev = target_valid;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        job_if.job_valid = 1'b0;
        job_if.job_pick  = '0;
        job_if.job_drop  = '0;
        #23;
        rst_n = 1'b1;
        tick();

        // Reset state
        checkOutput("reset job_ready", job_if.job_ready, 1);
        checkOutput("reset outputs", {target_valid, control_mag, pick_message, drop_message, busy}, 0);
        checkOutput("reset target", target_node, 0);
        checkOutput("reset jobs_done", jobs_done, 0);

        // 1: single job (30,17) with exact timing
        applyStimulus(32'd30, 32'd17);
        checkOutput("t1 tv after write", target_valid, 0);
        tick();
        checkOutput("t1 tv latency", target_valid, 1);
        checkOutput("t1 target pick", target_node, 30);
        arrive(32'd30);
        checkOutput("t1 mag on grab", control_mag, 1);
        wait_sig(1, "t1 pick", n);
        checkOutput("t1 pick delay", n, SETTLE);
        checkOutput("t1 mag go_drop", control_mag, 1);
        checkOutput("t1 target drop", target_node, 17);
        arrive(32'd17);
        checkOutput("t1 mag release", control_mag, 0);
        wait_sig(2, "t1 drop", n);
        checkOutput("t1 drop delay", n, SETTLE);
        checkOutput("t1 jobs_done", jobs_done, 1);
        checkOutput("t1 busy idle", busy, 0);

        // 2: job A in flight, then five offers; only four fit
        applyStimulus(32'd30, 32'd17);
        wait_sig(0, "t2 target", n);
        applyStimulus(32'd25, 32'd25);
        applyStimulus(32'd40, 32'd41);
        applyStimulus(32'd42, 32'd43);
        applyStimulus(32'd44, 32'd45);
        checkOutput("t2 full ready", job_if.job_ready, 0);
        job_if.job_pick  = 32'd46;
        job_if.job_drop  = 32'd47;
        job_if.job_valid = 1'b1;

        // 3: non-target edge then held level at the target must not arrive
        node = 32'd29;
        node_detected = 1'b1;
        tick();
        node = 32'd30;
        tick();
        tick();
        tick();
        checkOutput("t3 still go_pick", {target_valid, control_mag}, 2'b10);
        checkOutput("t3 target", target_node, 30);
        checkOutput("t3 5th refused", job_if.job_ready, 0);
        node_detected = 1'b0;
        tick();
        arrive(32'd30);
        checkOutput("t3 fresh edge grab", control_mag, 1);
        wait_sig(1, "t3 pick", n);
        arrive(32'd17);
        wait_sig(2, "t3 drop", n);
        checkOutput("t2 ready at idle", job_if.job_ready, 0);
        tick();
        checkOutput("t2 ready after pop", job_if.job_ready, 1);
        tick();
        job_if.job_valid = 1'b0;
        expect_job(32'd46, 32'd47);
        checkOutput("t2 full again", job_if.job_ready, 0);

        // 4: job (25,25) needs a second edge to release
        node = 32'd25;
        node_detected = 1'b1;
        tick();
        checkOutput("t4 grab", control_mag, 1);
        wait_sig(1, "t4 pick", n);
        tick();
        tick();
        tick();
        checkOutput("t4 held in go_drop", {target_valid, control_mag}, 2'b11);
        node_detected = 1'b0;
        tick();
        arrive(32'd25);
        checkOutput("t4 release", control_mag, 0);
        wait_sig(2, "t4 drop", n);

        finish_job(32'd40, 32'd41);
        finish_job(32'd42, 32'd43);
        finish_job(32'd44, 32'd45);
        finish_job(32'd46, 32'd47);
        checkOutput("t4 jobs_done 7", jobs_done, 7);

        // 5: reset mid-GRAB and mid-GO_DROP with jobs still queued
        applyStimulus(32'd60, 32'd61);
        wait_sig(0, "t5a target", n);
        applyStimulus(32'd62, 32'd63);
        applyStimulus(32'd64, 32'd65);
        arrive(32'd60);
        checkOutput("t5a in grab", control_mag, 1);
        mid_cycle_reset("t5a");

        applyStimulus(32'd70, 32'd71);
        wait_sig(0, "t5b target", n);
        applyStimulus(32'd72, 32'd73);
        arrive(32'd70);
        wait_sig(1, "t5b pick", n);
        tick();
        checkOutput("t5b in go_drop", control_mag, 1);
        mid_cycle_reset("t5b");

        // 6: counter wrap and push during RELEASE
        for (int i = 0; i < 255; i++) begin
            run_job(32'd1000 + 32'(i), 32'd2000 + 32'(i));
        end
        checkOutput("t6 jobs_done 255", jobs_done, 255);
        applyStimulus(32'd1255, 32'd2255);
        wait_sig(0, "t6 target", n);
        arrive(32'd1255);
        wait_sig(1, "t6 pick", n);
        arrive(32'd2255);
        applyStimulus(32'd3000, 32'd3001);
        wait_sig(2, "t6 drop", n);
        checkOutput("t6 wrap", jobs_done, 0);
        tick();
        checkOutput("t6 next start", {target_valid, busy}, 2'b11);
        checkOutput("t6 next target", target_node, 3000);
        finish_job(32'd3000, 32'd3001);
        checkOutput("t6 after wrap", jobs_done, 1);

        tick();
        tick();
        checkOutput("sb drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
